isp_stream_scheduler: RTL and testbench

Byte-clock-domain controller that sits between the CSI-2 packet decoder and the `isp_pipeline` array. It tracks frame and line packet sequences per virtual channel and maps each channel onto a pipeline. It generates the per-pipeline `frame_valid`/`line_valid` qualifiers and the one-hot `activate_stream` select. It also latches a per-frame shadow copy of each pipeline's configuration registers, so reprogramming mid-frame never corrupts an image.

---
 rtl/isp_stream_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_isp_stream_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/isp_stream_scheduler.sv
// Per-virtual-channel frame/line scheduler feeding the ISP pipeline array.
// Optional frame-end line-count check: define ISP_SCHED_LINE_CHECK_EN.
module isp_stream_scheduler #(
    parameter int PIPELINE_WIDTH = 4,
    parameter int LINE_CNT_W     = 16
) (
    input  logic                                 byte_clk_i,
    input  logic                                 reset_n_i,
    input  logic [PIPELINE_WIDTH-1:0]            cfg_enable_reg_i,
    input  logic [2*PIPELINE_WIDTH-1:0]          cfg_vc_reg_i,
    input  logic [6*PIPELINE_WIDTH-1:0]          cfg_data_type_reg_i,
    input  logic [2*PIPELINE_WIDTH-1:0]          cfg_bayer_reg_i,
    input  logic [3*PIPELINE_WIDTH-1:0]          cfg_ppc_reg_i,
    input  logic [LINE_CNT_W*PIPELINE_WIDTH-1:0] cfg_lines_reg_i,
    input  logic                                 pkt_valid_i,
    input  logic [1:0]                           pkt_vc_i,
    input  logic [5:0]                           pkt_dt_i,
    input  logic                                 pkt_end_i,
    output logic [PIPELINE_WIDTH-1:0]            frame_valid_o,
    output logic [PIPELINE_WIDTH-1:0]            line_valid_o,
    output logic [PIPELINE_WIDTH-1:0]            activate_stream_o,
    output logic [6*PIPELINE_WIDTH-1:0]          data_type_o,
    output logic [2*PIPELINE_WIDTH-1:0]          bayer_o,
    output logic [3*PIPELINE_WIDTH-1:0]          ppc_o,
    output logic [LINE_CNT_W*PIPELINE_WIDTH-1:0] line_count_o,
    output logic [PIPELINE_WIDTH-1:0]            frame_done_o,
    output logic                                 err_seq_o,
    output logic                                 err_dt_o,
    output logic [PIPELINE_WIDTH-1:0]            err_lines_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_LINE} state_t;

    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    state_t                  state_q [PIPELINE_WIDTH];
    state_t                  state_d [PIPELINE_WIDTH];
    logic [LINE_CNT_W-1:0]   count_q [PIPELINE_WIDTH];
    logic [LINE_CNT_W-1:0]   count_d [PIPELINE_WIDTH];
    logic [1:0]              vc_q    [PIPELINE_WIDTH];
    logic [PIPELINE_WIDTH-1:0] match, tgt, load_shadow, done_d;
    logic                    err_seq_d, err_dt_d;
    logic                    is_long, is_fs, is_fe;

    assign is_long = (pkt_dt_i >= DT_LONG_MIN);
    assign is_fs   = (pkt_dt_i == DT_FS);
    assign is_fe   = (pkt_dt_i == DT_FE);

    // A pipeline mid-frame keeps its frame-start VC and enable until it returns to IDLE.
    always_comb begin
        for (int p = 0; p < PIPELINE_WIDTH; p++) begin
            if (state_q[p] != ST_IDLE)
                match[p] = (vc_q[p] == pkt_vc_i);
            else
                match[p] = cfg_enable_reg_i[p] && (cfg_vc_reg_i[2*p +: 2] == pkt_vc_i);
        end
    end

    assign tgt = match & (~match + 1'b1);

`ifdef ISP_SCHED_LINE_CHECK_EN
    logic [PIPELINE_WIDTH-1:0] lines_d;
`else
    logic unused_cfg_lines;
    assign unused_cfg_lines = ^cfg_lines_reg_i;
`endif

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        err_seq_d   = 1'b0;
        err_dt_d    = 1'b0;
        done_d      = '0;
        load_shadow = '0;
`ifdef ISP_SCHED_LINE_CHECK_EN
        lines_d     = '0;
`endif
        for (int p = 0; p < PIPELINE_WIDTH; p++) begin
            state_d[p] = state_q[p];
            count_d[p] = count_q[p];
            // The payload end is applied first so a same-cycle header sees FRAME.
            if (pkt_end_i && state_q[p] == ST_LINE) begin
                state_d[p] = ST_FRAME;
                if (count_q[p] != '1)
                    count_d[p] = count_q[p] + 1'b1;
            end
            if (pkt_valid_i && tgt[p]) begin
                case (state_d[p])
                    ST_IDLE: begin
                        if (is_fs) begin
                            state_d[p]     = ST_FRAME;
                            count_d[p]     = '0;
                            load_shadow[p] = 1'b1;
                        end else begin
                            err_seq_d = 1'b1;
                        end
                    end
                    ST_FRAME: begin
                        if (is_long) begin
                            if (pkt_dt_i == data_type_o[6*p +: 6])
                                state_d[p] = ST_LINE;
                            else
                                err_dt_d = 1'b1;
                        end else if (is_fe) begin
                            state_d[p] = ST_IDLE;
                            done_d[p]  = 1'b1;
`ifdef ISP_SCHED_LINE_CHECK_EN
                            lines_d[p] = (count_d[p] != cfg_lines_reg_i[LINE_CNT_W*p +: LINE_CNT_W]);
`endif
                        end else if (is_fs) begin
                            err_seq_d      = 1'b1;
                            count_d[p]     = '0;
                            load_shadow[p] = 1'b1;
                        end
                    end
                    ST_LINE: begin
                        err_seq_d = 1'b1;
                        if (is_fe) begin
                            state_d[p] = ST_IDLE;
                        end else if (is_fs) begin
                            state_d[p]     = ST_FRAME;
                            count_d[p]     = '0;
                            load_shadow[p] = 1'b1;
                        end else begin
                            state_d[p] = ST_FRAME;
                        end
                    end
                    default: state_d[p] = ST_IDLE;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
    // NOTE: the async reset clears every flop, shadow registers included, so outputs are defined from reset.
    always_ff @(posedge byte_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int p = 0; p < PIPELINE_WIDTH; p++) begin
                state_q[p] <= ST_IDLE;
                count_q[p] <= '0;
                vc_q[p]    <= '0;
            end
            frame_valid_o     <= '0;
            line_valid_o      <= '0;
            activate_stream_o <= '0;
            data_type_o       <= '0;
            bayer_o           <= '0;
            ppc_o             <= '0;
            frame_done_o      <= '0;
            err_seq_o         <= 1'b0;
            err_dt_o          <= 1'b0;
        end else begin
            for (int p = 0; p < PIPELINE_WIDTH; p++) begin
                state_q[p]           <= state_d[p];
                count_q[p]           <= count_d[p];
                frame_valid_o[p]     <= (state_d[p] != ST_IDLE);
                line_valid_o[p]      <= (state_d[p] == ST_LINE);
                activate_stream_o[p] <= (state_d[p] == ST_LINE);
                if (load_shadow[p]) begin
                    vc_q[p]              <= cfg_vc_reg_i[2*p +: 2];
                    data_type_o[6*p +: 6] <= cfg_data_type_reg_i[6*p +: 6];
                    bayer_o[2*p +: 2]     <= cfg_bayer_reg_i[2*p +: 2];
                    ppc_o[3*p +: 3]       <= cfg_ppc_reg_i[3*p +: 3];
                end
            end
            frame_done_o <= done_d;
            err_seq_o    <= err_seq_d;
            err_dt_o     <= err_dt_d;
        end
    end

    for (genvar p = 0; p < PIPELINE_WIDTH; p++) begin : g_count
        assign line_count_o[LINE_CNT_W*p +: LINE_CNT_W] = count_q[p];
    end

`ifdef ISP_SCHED_LINE_CHECK_EN
    always_ff @(posedge byte_clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            err_lines_o <= '0;
        else
            err_lines_o <= lines_d;
    end
`else
    assign err_lines_o = '0;
`endif

endmodule

// File: tb/tb_isp_stream_scheduler.sv
// Directed bench for isp_stream_scheduler: frame/line sequencing, shadow config, priority and errors.
module tb_isp_stream_scheduler;

    logic        byte_clk_i = 1'b0;
    logic        reset_n_i;
    logic [3:0]  cfg_enable_reg_i;
    logic [7:0]  cfg_vc_reg_i;
    logic [23:0] cfg_data_type_reg_i;
    logic [7:0]  cfg_bayer_reg_i;
    logic [11:0] cfg_ppc_reg_i;
    logic [63:0] cfg_lines_reg_i;
    logic        pkt_valid_i;
    logic [1:0]  pkt_vc_i;
    logic [5:0]  pkt_dt_i;
    logic        pkt_end_i;
    logic [3:0]  frame_valid_o, line_valid_o, activate_stream_o;
    logic [23:0] data_type_o;
    logic [7:0]  bayer_o;
    logic [11:0] ppc_o;
    logic [63:0] line_count_o;
    logic [3:0]  frame_done_o;
    logic        err_seq_o, err_dt_o;
    logic [3:0]  err_lines_o;

    int vectors    = 0;
    int miscompares = 0;

    localparam logic [5:0] FS = 6'h00, FE = 6'h01, LS = 6'h02, LE = 6'h03, RAW8 = 6'h2A, RAW10 = 6'h2B;

    isp_stream_scheduler #(.PIPELINE_WIDTH(4), .LINE_CNT_W(16)) dut (
        .byte_clk_i(byte_clk_i), .reset_n_i(reset_n_i),
        .cfg_enable_reg_i(cfg_enable_reg_i), .cfg_vc_reg_i(cfg_vc_reg_i),
        .cfg_data_type_reg_i(cfg_data_type_reg_i), .cfg_bayer_reg_i(cfg_bayer_reg_i),
        .cfg_ppc_reg_i(cfg_ppc_reg_i), .cfg_lines_reg_i(cfg_lines_reg_i),
        .pkt_valid_i(pkt_valid_i), .pkt_vc_i(pkt_vc_i), .pkt_dt_i(pkt_dt_i), .pkt_end_i(pkt_end_i),
        .frame_valid_o(frame_valid_o), .line_valid_o(line_valid_o),
        .activate_stream_o(activate_stream_o), .data_type_o(data_type_o), .bayer_o(bayer_o),
        .ppc_o(ppc_o), .line_count_o(line_count_o), .frame_done_o(frame_done_o),
        .err_seq_o(err_seq_o), .err_dt_o(err_dt_o), .err_lines_o(err_lines_o)
    );

    always #5 byte_clk_i = ~byte_clk_i;

    // Each stimulus task starts and ends on a falling edge; outputs read afterwards are cycle N+1.
    task automatic hdr(input logic [1:0] vc, input logic [5:0] dt);
        pkt_valid_i = 1'b1; pkt_vc_i = vc; pkt_dt_i = dt;
        @(negedge byte_clk_i);
        pkt_valid_i = 1'b0;
    endtask

    task automatic pend();
        pkt_end_i = 1'b1;
        @(negedge byte_clk_i);
        pkt_end_i = 1'b0;
    endtask

    task automatic end_and_hdr(input logic [1:0] vc, input logic [5:0] dt);
        pkt_end_i = 1'b1; pkt_valid_i = 1'b1; pkt_vc_i = vc; pkt_dt_i = dt;
        @(negedge byte_clk_i);
        pkt_end_i = 1'b0; pkt_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        cfg_enable_reg_i = 4'b0001; cfg_vc_reg_i = 8'h00;
        cfg_data_type_reg_i = {4{RAW8}}; cfg_bayer_reg_i = 8'h00;
        cfg_ppc_reg_i = {4{3'd1}}; cfg_lines_reg_i = {4{16'd512}};
        pkt_valid_i = 1'b0; pkt_vc_i = 2'd0; pkt_dt_i = 6'd0; pkt_end_i = 1'b0;
        repeat (3) @(negedge byte_clk_i);
        reset_n_i = 1'b1;
        @(negedge byte_clk_i);
        if ({frame_valid_o, line_valid_o, activate_stream_o, frame_done_o, err_lines_o} !== 20'h0) begin
            $display("FAIL reset_vec: got %h exp 0", {frame_valid_o, line_valid_o, activate_stream_o, frame_done_o, err_lines_o}); miscompares++; end
        vectors++;
        if ({data_type_o, bayer_o, ppc_o, line_count_o, err_seq_o, err_dt_o} !== '0) begin
            $display("FAIL reset_shadow: dt %h bayer %h ppc %h cnt %h", data_type_o, bayer_o, ppc_o, line_count_o); miscompares++; end
        vectors++;
    endtask

    task automatic test_normal_frame();
        hdr(2'd0, FS);
        if (frame_valid_o !== 4'b0001) begin $display("FAIL nf_fs_fv: got %b exp 0001", frame_valid_o); miscompares++; end
        vectors++;
        if (data_type_o[5:0] !== RAW8) begin $display("FAIL nf_shadow_dt: got %h exp 2a", data_type_o[5:0]); miscompares++; end
        vectors++;
        for (int i = 0; i < 512; i++) begin
            hdr(2'd0, RAW8);
            if (activate_stream_o !== 4'b0001 || line_valid_o !== 4'b0001) begin
                $display("FAIL nf_line_act[%0d]: got act %b lv %b exp 0001", i, activate_stream_o, line_valid_o); miscompares++; end
            vectors++;
            @(negedge byte_clk_i);
            pend();
            if (activate_stream_o !== 4'b0000 || err_seq_o !== 1'b0 || err_dt_o !== 1'b0) begin
                $display("FAIL nf_line_end[%0d]: got act %b seq %b dt %b exp 0000 0 0", i, activate_stream_o, err_seq_o, err_dt_o); miscompares++; end
            vectors++;
        end
        hdr(2'd0, FE);
        if (frame_done_o !== 4'b0001 || frame_valid_o !== 4'b0000) begin
            $display("FAIL nf_fe: got done %b fv %b exp 0001 0000", frame_done_o, frame_valid_o); miscompares++; end
        vectors++;
        if (line_count_o[15:0] !== 16'd512) begin $display("FAIL nf_count: got %0d exp 512", line_count_o[15:0]); miscompares++; end
        vectors++;
        if (err_lines_o !== 4'b0000 || err_seq_o !== 1'b0) begin
            $display("FAIL nf_fe_err: got lines %b seq %b exp 0000 0", err_lines_o, err_seq_o); miscompares++; end
        vectors++;
        @(negedge byte_clk_i);
        if (frame_done_o !== 4'b0000) begin $display("FAIL nf_done_single: got %b exp 0000", frame_done_o); miscompares++; end
        vectors++;
    endtask

    task automatic test_shadow();
        cfg_bayer_reg_i = 8'b00_00_00_01;
        hdr(2'd0, FS);
        if (bayer_o[1:0] !== 2'b01) begin $display("FAIL sh_load: got %b exp 01", bayer_o[1:0]); miscompares++; end
        vectors++;
        cfg_bayer_reg_i = 8'b00_00_00_00;
        hdr(2'd0, LS);
        hdr(2'd0, RAW8);
        pend();
        hdr(2'd0, LE);
        if (bayer_o[1:0] !== 2'b01 || err_seq_o !== 1'b0) begin
            $display("FAIL sh_hold: got bayer %b seq %b exp 01 0", bayer_o[1:0], err_seq_o); miscompares++; end
        vectors++;
        hdr(2'd0, FE);
        hdr(2'd0, FS);
        if (bayer_o[1:0] !== 2'b00) begin $display("FAIL sh_reload: got %b exp 00", bayer_o[1:0]); miscompares++; end
        vectors++;
        hdr(2'd0, FE);
    endtask

    task automatic test_vc_priority();
        cfg_enable_reg_i = 4'b0110; cfg_vc_reg_i = 8'b00_11_11_00;
        hdr(2'd3, FS);
        if (frame_valid_o !== 4'b0010) begin $display("FAIL vc_prio: got %b exp 0010", frame_valid_o); miscompares++; end
        vectors++;
        hdr(2'd3, FE);
        if (frame_done_o !== 4'b0010 || frame_valid_o !== 4'b0000) begin
            $display("FAIL vc_prio_fe: got done %b fv %b exp 0010 0000", frame_done_o, frame_valid_o); miscompares++; end
        vectors++;
        hdr(2'd1, FS);
        if (frame_valid_o !== 4'b0000 || err_seq_o !== 1'b0) begin
            $display("FAIL vc_nomatch: got fv %b seq %b exp 0000 0", frame_valid_o, err_seq_o); miscompares++; end
        vectors++;
        cfg_enable_reg_i = 4'b0001; cfg_vc_reg_i = 8'h00;
    endtask

    task automatic test_seq_errors();
        hdr(2'd0, FS);
        hdr(2'd0, RAW8);
        hdr(2'd0, FE);
        if (err_seq_o !== 1'b1 || frame_valid_o !== 4'b0000 || frame_done_o !== 4'b0000) begin
            $display("FAIL seq_fe_in_line: got seq %b fv %b done %b exp 1 0000 0000", err_seq_o, frame_valid_o, frame_done_o); miscompares++; end
        vectors++;
        hdr(2'd0, LE);
        if (err_seq_o !== 1'b1 || frame_valid_o !== 4'b0000) begin
            $display("FAIL seq_le_idle: got seq %b fv %b exp 1 0000", err_seq_o, frame_valid_o); miscompares++; end
        vectors++;
        @(negedge byte_clk_i);
        if (err_seq_o !== 1'b0) begin $display("FAIL seq_pulse_width: got %b exp 0", err_seq_o); miscompares++; end
        vectors++;
        hdr(2'd0, FS);
        hdr(2'd0, FS);
        if (err_seq_o !== 1'b1 || frame_valid_o !== 4'b0001) begin
            $display("FAIL seq_fs_in_frame: got seq %b fv %b exp 1 0001", err_seq_o, frame_valid_o); miscompares++; end
        vectors++;
        hdr(2'd0, FE);
    endtask

    task automatic test_dt_mismatch();
        hdr(2'd0, FS);
        hdr(2'd0, RAW10);
        if (err_dt_o !== 1'b1 || line_valid_o !== 4'b0000 || frame_valid_o !== 4'b0001) begin
            $display("FAIL dt_mismatch: got dt %b lv %b fv %b exp 1 0000 0001", err_dt_o, line_valid_o, frame_valid_o); miscompares++; end
        vectors++;
        hdr(2'd0, FE);
        if (frame_done_o !== 4'b0001) begin $display("FAIL dt_fe: got %b exp 0001", frame_done_o); miscompares++; end
        vectors++;
    endtask

    task automatic test_line_check();
        cfg_lines_reg_i[15:0] = 16'd4;
        hdr(2'd0, FS);
        for (int i = 0; i < 3; i++) begin
            hdr(2'd0, RAW8);
            pend();
        end
        hdr(2'd0, FE);
`ifdef ISP_SCHED_LINE_CHECK_EN
        if (err_lines_o !== 4'b0001 || frame_done_o !== 4'b0001) begin
            $display("FAIL lines_mismatch: got lines %b done %b exp 0001 0001", err_lines_o, frame_done_o); miscompares++; end
`else
        if (err_lines_o !== 4'b0000 || frame_done_o !== 4'b0001) begin
            $display("FAIL lines_disabled: got lines %b done %b exp 0000 0001", err_lines_o, frame_done_o); miscompares++; end
`endif
        vectors++;
        if (line_count_o[15:0] !== 16'd3) begin $display("FAIL lines_count: got %0d exp 3", line_count_o[15:0]); miscompares++; end
        vectors++;
    endtask

    task automatic test_back_to_back();
        hdr(2'd0, FS);
        pend();
        if (frame_valid_o !== 4'b0001 || line_count_o[15:0] !== 16'd0 || err_seq_o !== 1'b0) begin
            $display("FAIL b2b_stray_end: got fv %b cnt %0d seq %b exp 0001 0 0", frame_valid_o, line_count_o[15:0], err_seq_o); miscompares++; end
        vectors++;
        hdr(2'd0, RAW8);
        end_and_hdr(2'd0, RAW8);
        if (line_valid_o !== 4'b0001 || line_count_o[15:0] !== 16'd1 || err_seq_o !== 1'b0) begin
            $display("FAIL b2b_end_line: got lv %b cnt %0d seq %b exp 0001 1 0", line_valid_o, line_count_o[15:0], err_seq_o); miscompares++; end
        vectors++;
        end_and_hdr(2'd0, FE);
        if (frame_done_o !== 4'b0001 || frame_valid_o !== 4'b0000 || line_count_o[15:0] !== 16'd2) begin
            $display("FAIL b2b_end_fe: got done %b fv %b cnt %0d exp 0001 0000 2", frame_done_o, frame_valid_o, line_count_o[15:0]); miscompares++; end
        vectors++;
    endtask

    task automatic test_disable_mid_frame();
        hdr(2'd0, FS);
        cfg_enable_reg_i = 4'b0000;
        hdr(2'd0, RAW8);
        if (line_valid_o !== 4'b0001) begin $display("FAIL dis_line: got %b exp 0001", line_valid_o); miscompares++; end
        vectors++;
        pend();
        hdr(2'd0, FE);
        if (frame_done_o !== 4'b0001) begin $display("FAIL dis_fe: got %b exp 0001", frame_done_o); miscompares++; end
        vectors++;
        hdr(2'd0, FS);
        if (frame_valid_o !== 4'b0000 || err_seq_o !== 1'b0) begin
            $display("FAIL dis_next_fs: got fv %b seq %b exp 0000 0", frame_valid_o, err_seq_o); miscompares++; end
        vectors++;
        cfg_enable_reg_i = 4'b0001;
    endtask

    task automatic test_reset_mid_line();
        hdr(2'd0, FS);
        hdr(2'd0, RAW8);
        #2 reset_n_i = 1'b0;
        #1;
        if (frame_valid_o !== 4'b0000 || line_valid_o !== 4'b0000) begin
            $display("FAIL rst_async: got fv %b lv %b exp 0000 0000", frame_valid_o, line_valid_o); miscompares++; end
        vectors++;
        @(negedge byte_clk_i);
        reset_n_i = 1'b1;
        @(negedge byte_clk_i);
        if (err_seq_o !== 1'b0 || frame_done_o !== 4'b0000 || line_count_o[15:0] !== 16'd0) begin
            $display("FAIL rst_after: got seq %b done %b cnt %0d exp 0 0000 0", err_seq_o, frame_done_o, line_count_o[15:0]); miscompares++; end
        vectors++;
    endtask

    initial begin
        test_reset();
        test_normal_frame();
        test_shadow();
        test_vc_priority();
        test_seq_errors();
        test_dt_mismatch();
        test_line_check();
        test_back_to_back();
        test_disable_mid_frame();
        test_reset_mid_line();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running exp finished");
        $fatal(1, "bench time limit reached");
    end

endmodule
